// File: rtl/rf_wb_queue_if.sv
// Bundle of producer, register-file write and lookup signals for rf_wb_queue.
// slave = the queue itself; master = the surrounding pipeline.
interface rf_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;

  logic          rf_hold;
  logic          rf_we;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;

  logic [AW-1:0] lk_rs1_addr;
  logic          lk_rs1_hit;
  logic [DW-1:0] lk_rs1_data;
  logic [AW-1:0] lk_rs2_addr;
  logic          lk_rs2_hit;
  logic [DW-1:0] lk_rs2_data;

  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_rd, in_data, rf_hold, lk_rs1_addr, lk_rs2_addr,
    output in_ready, rf_we, rf_rd_addr, rf_rd_data,
           lk_rs1_hit, lk_rs1_data, lk_rs2_hit, lk_rs2_data, count
  );

  modport master (
    output in_valid, in_rd, in_data, rf_hold, lk_rs1_addr, lk_rs2_addr,
    input  in_ready, rf_we, rf_rd_addr, rf_rd_data,
           lk_rs1_hit, lk_rs1_data, lk_rs2_hit, lk_rs2_data, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Writeback FIFO between result path and register-file write port, with
// newest-value lookup on two addresses. Optional zero-latency path: WBQ_BYPASS_EN.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic         clk,
  input  logic         rst,
  rf_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]  rd_q   [DEPTH];
  logic [AW-1:0]  rd_d   [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];
  logic [DW-1:0]  data_d [DEPTH];

  logic           head_valid;
  logic           q_we;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_data;
  logic           push_acc;
  logic           store;
  logic           bypass;

  logic [DEPTH-1:0] m1, m2;
  logic [PW-1:0]  scan_idx;
  logic           hit1, hit2;
  logic [DW-1:0]  lk1_data, lk2_data;

  assign head_valid = (count_q != '0);
  assign q_we       = head_valid && !bus.rf_hold;
  assign head_addr  = head_valid ? rd_q[rd_ptr_q]   : '0;
  assign head_data  = head_valid ? data_q[rd_ptr_q] : '0;

  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign push_acc     = bus.in_valid && bus.in_ready;

`ifdef WBQ_BYPASS_EN
  // An empty, unheld queue forwards the incoming result straight to the port.
  assign bypass         = !rst && !head_valid && !bus.rf_hold && push_acc && (bus.in_rd != '0);
  assign bus.rf_we      = q_we || bypass;
  assign bus.rf_rd_addr = bypass ? bus.in_rd   : head_addr;
  assign bus.rf_rd_data = bypass ? bus.in_data : head_data;
`else
  assign bypass         = 1'b0;
  assign bus.rf_we      = q_we;
  assign bus.rf_rd_addr = head_addr;
  assign bus.rf_rd_data = head_data;
`endif

  // x0 results complete the handshake but are never written.
  assign store     = push_acc && (bus.in_rd != '0) && !bypass;
  assign bus.count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    rd_d     = rd_q;
    data_d   = data_q;
    if (q_we) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (store) begin
      vld_d[wr_ptr_q]  = 1'b1;
      rd_d[wr_ptr_q]   = bus.in_rd;
      data_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(store) - CW'(q_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign m1[gi] = vld_q[gi] && (rd_q[gi] == bus.lk_rs1_addr) && (bus.lk_rs1_addr != '0);
      assign m2[gi] = vld_q[gi] && (rd_q[gi] == bus.lk_rs2_addr) && (bus.lk_rs2_addr != '0);
    end
  endgenerate

  // Walk from head to tail so the last match seen is the newest one.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    lk1_data = '0;
    lk2_data = '0;
    scan_idx = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (m1[scan_idx]) begin
        hit1     = 1'b1;
        lk1_data = data_q[scan_idx];
      end
      if (m2[scan_idx]) begin
        hit2     = 1'b1;
        lk2_data = data_q[scan_idx];
      end
    end
  end

  assign bus.lk_rs1_hit  = hit1;
  assign bus.lk_rs1_data = lk1_data;
  assign bus.lk_rs2_hit  = hit2;
  assign bus.lk_rs2_data = lk2_data;
endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue (DEPTH=4, AW=5, DW=32).
module tb_rf_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  rf_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [AW+DW-1:0] sb[$];
  int  pushed;
  int  cyc;
  bit  exp_ready;
  bit  exp_we;

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_rd       = '0;
    bus.in_data     = '0;
    bus.rf_hold     = 1'b0;
    bus.lk_rs1_addr = 5'd1;
    bus.lk_rs2_addr = 5'd2;

    // Reset state
    @(negedge clk); #1;
    chk("rst_count",    bus.count,       0);
    chk("rst_in_ready", bus.in_ready,    1);
    chk("rst_rf_we",    bus.rf_we,       0);
    chk("rst_rf_addr",  bus.rf_rd_addr,  0);
    chk("rst_rf_data",  bus.rf_rd_data,  0);
    chk("rst_hit1",     bus.lk_rs1_hit,  0);
    chk("rst_hit2",     bus.lk_rs2_hit,  0);
    chk("rst_lkdata1",  bus.lk_rs1_data, 0);

    // Single push, one-cycle latency (zero with bypass)
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd1;
    bus.in_data  = 32'h12345678;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("t1_byp_we",   bus.rf_we,      1);
    chk("t1_byp_addr", bus.rf_rd_addr, 1);
    chk("t1_byp_data", bus.rf_rd_data, 32'h12345678);
`else
    chk("t1_we_early", bus.rf_we, 0);
    chk("t1_cnt0",     bus.count, 0);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("t1_byp_we_after", bus.rf_we, 0);
    chk("t1_byp_cnt",      bus.count, 0);
`else
    chk("t1_we",      bus.rf_we,       1);
    chk("t1_addr",    bus.rf_rd_addr,  1);
    chk("t1_data",    bus.rf_rd_data,  32'h12345678);
    chk("t1_cnt1",    bus.count,       1);
    chk("t1_hit1",    bus.lk_rs1_hit,  1);
    chk("t1_lkdata1", bus.lk_rs1_data, 32'h12345678);
`endif
    @(negedge clk); #1;
    chk("t1_cnt_end", bus.count, 0);
    chk("t1_we_end",  bus.rf_we, 0);

    // Fill under hold, reject 5th, drain in order
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.rf_hold  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_rd    = AW'(k);
      bus.in_data  = 32'h100 + k;
      #1;
      chk("t2_ready", bus.in_ready, 1);
      chk("t2_cnt",   bus.count,    k - 1);
    end
    @(negedge clk);
    bus.in_rd   = 5'd5;
    bus.in_data = 32'h105;
    #1;
    chk("t2_full_cnt",   bus.count,      4);
    chk("t2_full_ready", bus.in_ready,   0);
    chk("t2_hold_we",    bus.rf_we,      0);
    chk("t2_head_addr",  bus.rf_rd_addr, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t2_no5th_cnt", bus.count, 4);
    @(negedge clk);
    bus.rf_hold = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_we",   bus.rf_we,      1);
      chk("t2_drain_addr", bus.rf_rd_addr, k);
      chk("t2_drain_data", bus.rf_rd_data, 32'h100 + k);
      chk("t2_drain_cnt",  bus.count,      5 - k);
      @(negedge clk); #1;
    end
    chk("t2_end_cnt", bus.count, 0);
    chk("t2_end_we",  bus.rf_we, 0);

    // Lookup returns the newest of two writes to the same register
    @(negedge clk);
    bus.rf_hold     = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_rd       = 5'd2;
    bus.in_data     = 32'hAAAA0000;
    bus.lk_rs1_addr = 5'd2;
    bus.lk_rs2_addr = 5'd3;
    #1;
    chk("t3_pushing_invisible", bus.lk_rs1_hit, 0);
    @(negedge clk);
    bus.in_data = 32'h87654321;
    #1;
    chk("t3_first_hit",  bus.lk_rs1_hit,  1);
    chk("t3_first_data", bus.lk_rs1_data, 32'hAAAA0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t3_hit1",  bus.lk_rs1_hit,  1);
    chk("t3_data1", bus.lk_rs1_data, 32'h87654321);
    chk("t3_hit2",  bus.lk_rs2_hit,  0);
    chk("t3_data2", bus.lk_rs2_data, 0);
    chk("t3_cnt",   bus.count,       2);
    chk("t3_we",    bus.rf_we,       0);
    @(negedge clk);
    bus.rf_hold = 1'b0;
    #1;
    chk("t3_wr1_we",   bus.rf_we,       1);
    chk("t3_wr1_data", bus.rf_rd_data,  32'hAAAA0000);
    chk("t3_wr1_lk",   bus.lk_rs1_data, 32'h87654321);
    @(negedge clk); #1;
    chk("t3_wr2_addr", bus.rf_rd_addr,  2);
    chk("t3_wr2_data", bus.rf_rd_data,  32'h87654321);
    chk("t3_pop_hit",  bus.lk_rs1_hit,  1);
    chk("t3_pop_data", bus.lk_rs1_data, 32'h87654321);
    @(negedge clk); #1;
    chk("t3_end_cnt",  bus.count,       0);
    chk("t3_end_hit",  bus.lk_rs1_hit,  0);
    chk("t3_end_data", bus.lk_rs1_data, 0);

    // x0 write is accepted and dropped
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_rd       = 5'd0;
    bus.in_data     = 32'hFFFFFFFF;
    bus.lk_rs1_addr = 5'd0;
    #1;
    chk("t4_ready", bus.in_ready, 1);
    chk("t4_we",    bus.rf_we,    0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("t4_cnt",    bus.count,       0);
    chk("t4_we2",    bus.rf_we,       0);
    chk("t4_hit",    bus.lk_rs1_hit,  0);
    chk("t4_lkdata", bus.lk_rs1_data, 0);

    // Continuous stream through a full queue, pointer wrap, FIFO order
    pushed = 0;
    cyc    = 0;
    @(negedge clk);
    while ((pushed < 16 || sb.size() != 0) && cyc < 200) begin
      bus.rf_hold  = (pushed < 4);
      bus.in_valid = (pushed < 16);
      bus.in_rd    = AW'((pushed % 31) + 1);
      bus.in_data  = 32'hC0DE0000 + pushed;
      #1;
      exp_ready = (sb.size() != DEPTH);
      exp_we    = (sb.size() != 0) && !bus.rf_hold;
      chk("t5_cnt",   bus.count,    sb.size());
      chk("t5_ready", bus.in_ready, exp_ready);
      chk("t5_we",    bus.rf_we,    exp_we);
      if (exp_we) begin
        chk("t5_addr", bus.rf_rd_addr, sb[0][AW+DW-1:DW]);
        chk("t5_data", bus.rf_rd_data, sb[0][DW-1:0]);
        void'(sb.pop_front());
      end
      if (bus.in_valid && exp_ready) begin
        sb.push_back({bus.in_rd, bus.in_data});
        pushed++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("t5_bounded", (cyc < 200), 1);
    bus.in_valid = 1'b0;
    bus.rf_hold  = 1'b1;

    // Asynchronous reset discards queued entries
    for (int k = 7; k <= 9; k++) begin
      bus.in_valid = 1'b1;
      bus.in_rd    = AW'(k);
      bus.in_data  = 32'h900 + k;
      @(negedge clk);
    end
    bus.in_valid    = 1'b0;
    bus.lk_rs1_addr = 5'd8;
    bus.lk_rs2_addr = 5'd9;
    #1;
    chk("t6_pre_cnt",  bus.count,       3);
    chk("t6_pre_hit",  bus.lk_rs1_hit,  1);
    chk("t6_pre_data", bus.lk_rs1_data, 32'h908);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_cnt",   bus.count,       0);
    chk("t6_rst_we",    bus.rf_we,       0);
    chk("t6_rst_hit1",  bus.lk_rs1_hit,  0);
    chk("t6_rst_hit2",  bus.lk_rs2_hit,  0);
    chk("t6_rst_data1", bus.lk_rs1_data, 0);
    chk("t6_rst_ready", bus.in_ready,    1);
    chk("t6_rst_addr",  bus.rf_rd_addr,  0);
    @(negedge clk);
    rst          = 1'b0;
    bus.rf_hold  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd10;
    bus.in_data  = 32'hBEEF0001;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("t6_byp_we",   bus.rf_we,      1);
    chk("t6_byp_addr", bus.rf_rd_addr, 10);
`else
    chk("t6_we_early", bus.rf_we, 0);
    chk("t6_cnt0",     bus.count, 0);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("t6_byp_cnt", bus.count, 0);
    chk("t6_byp_we2", bus.rf_we, 0);
`else
    chk("t6_we",   bus.rf_we,      1);
    chk("t6_addr", bus.rf_rd_addr, 10);
    chk("t6_data", bus.rf_rd_data, 32'hBEEF0001);
    chk("t6_cnt1", bus.count,      1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Writeback queue that sits between the execute/memory result path and the write port of the register file (we, rd_addr, rd_data).
- Buffers up to DEPTH completed results and drains them into the register file at one write per cycle.
- Provides a pending-write lookup on two read addresses, so decode can forward the newest queued value or stall.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept.
- in_rd  input  AW  destination register.
- in_data  input  DW  result value.
- rf_hold  input  1  suppresses draining this cycle.
- rf_we  output  1  register file write enable.
- rf_rd_addr  output  AW  register file write address.
- rf_rd_data  output  DW  register file write data.
- lk_rs1_addr  input  AW  lookup address 1.
- lk_rs1_hit  output  1  pending write to lk_rs1_addr.
- lk_rs1_data  output  DW  newest pending value for lk_rs1_addr.
- lk_rs2_addr, lk_rs2_hit, lk_rs2_data: same as the rs1 lookup, for address 2.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While rst is high:
  - rd/wr pointers = 0, count = 0, all entry valid bits = 0.
  - Outputs: rf_we=0, rf_rd_addr=0, rf_rd_data=0, in_ready=1, lk_*_hit=0, lk_*_data=0.
- Asserting rst mid-operation discards all queued entries immediately. A write not yet performed is lost.
- Push: the handshake completes when in_valid && in_ready. in_ready = (count != DEPTH). It is combinational from state only and never depends on in_valid or rf_hold.
- x0 filtering: if in_rd == 0, the handshake completes but nothing is stored and count is unchanged.
- Drain:
  - rf_we = (count != 0) && !rf_hold.
  - rf_rd_addr and rf_rd_data = head entry whenever count != 0, else 0.
  - Head pops on the clock edge where rf_we = 1.
- Latency: an entry accepted at edge N is presented at the register file port in the cycle after N, and written at edge N+1 at the earliest.
- Ordering: strict FIFO. Two writes to the same rd reach the register file in acceptance order.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Full queue: in_ready = 0 even if a pop occurs the same cycle. There is no pass-through on full.
- Pointer wrap: pointers wrap modulo DEPTH. count distinguishes full from empty.
- Lookup (combinational):
  - Scans valid entries only.
  - hit = 1 if any entry's rd equals the lookup address. data = value of the newest matching entry, i.e. the one closest to the tail.
  - A lookup address of 0 never hits. data = 0 when there is no hit.
  - The entry being popped this cycle still counts as a hit.
  - The entry being pushed this cycle is not visible until the next cycle.
- count: reflects registered occupancy and updates at the clock edge.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: when count == 0, !rf_hold, and an accepted push has in_rd != 0, the incoming entry drives rf_we/rf_rd_addr/rf_rd_data in the same cycle and is not stored (zero latency). In every other case behaviour is identical to the undefined build. The lookup outputs are unaffected.
- Undefined: no combinational path from in_* to rf_*. Minimum latency is one cycle, as stated above.

Test Plan:
- Reset then single push (rd=1, data=0x12345678) -> rf_we=1, rf_rd_addr=1, rf_rd_data=0x12345678 one cycle later (same cycle with WBQ_BYPASS_EN); count returns to 0.
- Hold rf_hold=1 and push rd=1..4 with DEPTH=4 -> count=4, in_ready=0, a 5th push is not accepted. Release rf_hold -> writes appear in order 1,2,3,4 on consecutive cycles.
- Push rd=2 data=0xAAAA0000, then rd=2 data=0x87654321 under rf_hold -> lk_rs1_addr=2 gives hit=1, data=0x87654321. lk_rs2_addr=3 gives hit=0, data=0.
- Push rd=0 data=0xFFFFFFFF -> handshake completes, count stays 0, rf_we never asserts. lk_rs1_addr=0 gives hit=0.
- Full queue with rf_hold=0 and continuous in_valid -> pointers wrap past DEPTH, FIFO order is preserved over 3*DEPTH entries, and no push is accepted while count==DEPTH.
- Assert rst with 3 entries queued -> in the same cycle count=0, rf_we=0, lk hits=0. After release, the next push is written normally.
